adc_sample_sequencer: RTL

Periodic sample scheduler for the on-chip modular ADC's Avalon-ST command/response interface. A programmable divider generates the audio sample tick. On each tick the block issues one packet of conversion commands, one per channel, over NUM_CH consecutive channels. It collects the matching responses and emits each result as a signed, left-justified 16-bit sample to the effects datapath, and it flags overruns and lost responses.

---
 rtl/adc_sample_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer
// Periodic sample scheduler for a modular ADC with Avalon-ST command and
// response streams. A free-running divider produces the sample tick. Each
// tick starts one packet of NUM_CH conversion commands on channels
// CH_BASE..CH_BASE+NUM_CH-1. Each matching response is returned as a signed,
// left-justified 16-bit sample. Overrun (tick during an active frame) and
// response timeout are reported as sticky flags.
//
// Ports
//   clk_adc_clk, reset_reset_n     : clock, async active-low reset
//   enable                         : run the tick divider (0 holds it at 0)
//   clear_flags                    : clears overrun / timeout_err
//   adc_command_*                  : Avalon-ST command source (valid/ready)
//   adc_response_*                 : Avalon-ST response sink (no backpressure)
//   sample_valid/index/data        : sample output, one-cycle valid pulse
//   frame_done                     : pulses with the last sample of a frame
//   overrun, timeout_err           : sticky error flags
module adc_sample_sequencer #(
   parameter int unsigned SAMPLE_DIV = 1024,
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned CH_BASE    = 1,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic        clk_adc_clk,
   input  logic        reset_reset_n,
   input  logic        enable,
   input  logic        clear_flags,
   output logic        adc_command_valid,
   output logic [4:0]  adc_command_channel,
   output logic        adc_command_startofpacket,
   output logic        adc_command_endofpacket,
   input  logic        adc_command_ready,
   input  logic        adc_response_valid,
   input  logic [4:0]  adc_response_channel,
   input  logic [11:0] adc_response_data,
   input  logic        adc_response_startofpacket,
   input  logic        adc_response_endofpacket,
   output logic        sample_valid,
   output logic [1:0]  sample_index,
   output logic [15:0] sample_data,
   output logic        frame_done,
   output logic        overrun,
   output logic        timeout_err
);

   localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam int unsigned IDX_W = 2;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_CMD      = 2'd1,
      S_WAIT_RSP = 2'd2
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [TMR_W-1:0]   timer_q;
   logic [IDX_W-1:0]   idx_q;
   logic [IDX_W-1:0]   idx_nxt_c;
   logic               tick_c;
   logic               rsp_hit_c;

   // Packet framing bits of the response stream carry no extra information.
   logic unused_rsp_framing;
   assign unused_rsp_framing = adc_response_startofpacket ^ adc_response_endofpacket;

   function automatic logic [4:0] chan_of(input logic [IDX_W-1:0] idx);
      return 5'(CH_BASE) + 5'(idx);
   endfunction

   // Sample tick divider: tick on the last count, held at 0 while disabled.
   always_comb begin
      cnt_d  = '0;
      tick_c = 1'b0;
      if (enable) begin
         tick_c = (cnt_q == CNT_LAST);
         cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_adc_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign idx_nxt_c = idx_q + IDX_W'(1);
   assign rsp_hit_c = adc_response_valid && (adc_response_channel == chan_of(idx_q));

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk_adc_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q                   <= S_IDLE;
         idx_q                     <= '0;
         timer_q                   <= '0;
         adc_command_valid         <= 1'b0;
         adc_command_channel       <= '0;
         adc_command_startofpacket <= 1'b0;
         adc_command_endofpacket   <= 1'b0;
         sample_valid              <= 1'b0;
         sample_index              <= '0;
         sample_data               <= '0;
         frame_done                <= 1'b0;
         overrun                   <= 1'b0;
         timeout_err               <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         frame_done   <= 1'b0;

         // Clear first so that a same-cycle set below takes priority.
         if (clear_flags) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
         end

         // A tick during an active frame is dropped, not queued.
         if (tick_c && (state_q != S_IDLE)) begin
            overrun <= 1'b1;
         end

         case (state_q)
            S_IDLE: begin
               if (tick_c) begin
                  idx_q                     <= '0;
                  state_q                   <= S_CMD;
                  adc_command_valid         <= 1'b1;
                  adc_command_channel       <= chan_of('0);
                  adc_command_startofpacket <= 1'b1;
                  adc_command_endofpacket   <= (IDX_LAST == '0);
               end
            end

            // Command is held stable until the ADC accepts it.
            S_CMD: begin
               if (adc_command_ready) begin
                  adc_command_valid <= 1'b0;
                  timer_q           <= '0;
                  state_q           <= S_WAIT_RSP;
               end
            end

            // Mismatched responses are dropped; an accepted response wins
            // over a timeout occurring in the same cycle.
            S_WAIT_RSP: begin
               if (rsp_hit_c) begin
                  sample_valid <= 1'b1;
                  sample_index <= 2'(idx_q);
                  // Offset-binary to two's complement, left-justified.
                  sample_data  <= {~adc_response_data[11], adc_response_data[10:0], 4'b0000};
                  if (idx_q == IDX_LAST) begin
                     frame_done <= 1'b1;
                     state_q    <= S_IDLE;
                  end else begin
                     idx_q                     <= idx_nxt_c;
                     state_q                   <= S_CMD;
                     adc_command_valid         <= 1'b1;
                     adc_command_channel       <= chan_of(idx_nxt_c);
                     adc_command_startofpacket <= 1'b0;
                     adc_command_endofpacket   <= (idx_nxt_c == IDX_LAST);
                  end
               end else if (timer_q == TMR_LAST) begin
                  timeout_err <= 1'b1;
                  state_q     <= S_IDLE;
               end else begin
                  timer_q <= timer_q + TMR_W'(1);
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
